// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit 3-sample majority vote,
// one-cycle valid / framing-error strobes.
module uart_rx #(
    parameter int TICKS_PER_BIT      = 32,
    parameter int TICKS_PER_BIT_SIZE = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_din,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int MID = TICKS_PER_BIT / 2;
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_ONE  = TICKS_PER_BIT_SIZE'(1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_LAST = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_VA   = TICKS_PER_BIT_SIZE'(MID - 1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_VB   = TICKS_PER_BIT_SIZE'(MID);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_VC   = TICKS_PER_BIT_SIZE'(MID + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        BITS      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t                        state_reg,  state_next;
    logic [TICKS_PER_BIT_SIZE-1:0] tick_reg,   tick_next;
    logic [2:0]                    bit_reg,    bit_next;
    logic [7:0]                    shift_reg,  shift_next;
    logic [7:0]                    data_reg,   data_next;
    logic [1:0]                    samp_reg,   samp_next;
    logic                          valid_reg,  valid_next;
    logic                          err_reg,    err_next;
    logic                          s1_reg,     s2_reg;
    logic                          vote;
    logic                          vote_now;
    logic                          tick_last;

    // Third sample is the live s2 value, so the majority is ready at MID+1.
    assign vote      = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & s2_reg) | (samp_reg[1] & s2_reg);
    assign vote_now  = (tick_reg == TICK_VC);
    assign tick_last = (tick_reg == TICK_LAST);

    always_comb begin
        state_next = state_reg;
        tick_next  = '0;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        samp_next  = samp_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;

        if (tick_reg == TICK_VA) samp_next[0] = s2_reg;
        if (tick_reg == TICK_VB) samp_next[1] = s2_reg;

        case (state_reg)
            IDLE: begin
                if (!s2_reg) state_next = START;
            end
            START: begin
                tick_next = tick_last ? '0 : tick_reg + TICK_ONE;
                if (vote_now && vote) begin
                    state_next = IDLE;
                    tick_next  = '0;
                end else if (tick_last) begin
                    state_next = BITS;
                    bit_next   = 3'd0;
                end
            end
            BITS: begin
                tick_next = tick_last ? '0 : tick_reg + TICK_ONE;
                if (vote_now) shift_next = {vote, shift_reg[7:1]};
                if (tick_last) begin
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        bit_next   = 3'd0;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                tick_next = tick_last ? '0 : tick_reg + TICK_ONE;
                // Leave at mid-stop-bit so a back-to-back start edge is caught.
                if (vote_now) begin
                    tick_next = '0;
                    if (vote) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (s2_reg) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_reg    <= 1'b1;
            s2_reg    <= 1'b1;
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            samp_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            s1_reg    <= i_din;
            s2_reg    <= s1_reg;
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            samp_reg  <= samp_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    assign o_data      = data_reg;
    assign o_valid     = valid_reg;
    assign o_frame_err = err_reg;
    assign o_busy      = (state_reg == START) || (state_reg == BITS) ||
                         (state_reg == STOP)  || (state_reg == WAIT_HIGH);

endmodule
